// File: rtl/serial_add_sequencer.sv
// -----------------------------------------------------------------------------
// serial_add_sequencer
//   Bit-serial add/subtract controller. A single 1-bit full-adder cell (two half
//   adders plus an OR) is reused across all WIDTH bits of the operand pair,
//   LSB first, one bit per clock. The host starts an operation with a one-cycle
//   start request in IDLE and receives a one-cycle done pulse with the result.
//
// Parameters
//   WIDTH  operand/result width in bits (2..32)
//
// Ports
//   clk    in   rising-edge clock
//   rst    in   synchronous active-high reset
//   start  in   request, accepted only in IDLE
//   sub    in   0: a+b+cin, 1: a-b (a + ~b + 1, cin ignored)
//   cin    in   carry-in for add
//   a, b   in   operands, sampled only on the accepting edge
//   busy   out  high while an operation is in RUN or DONE
//   done   out  one-cycle pulse, sum/cout/ovf valid
//   sum    out  result, held until the next operation completes
//   cout   out  carry out of the MSB (subtract: 1 = no borrow)
//   ovf    out  signed overflow (carry into MSB xor carry out of MSB)
// -----------------------------------------------------------------------------
module serial_add_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic             cin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;

    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_result;
    logic             r_c;
    logic [CNT_W-1:0] r_cnt;

    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;

    logic             w_accept;
    logic             w_last;
    logic             w_p;
    logic             w_g1;
    logic             w_g2;
    logic             w_s;
    logic             w_c_next;

    // Shared full-adder cell built from two half adders and an OR.
    assign w_p      = r_a_sh[0] ^ r_b_sh[0];
    assign w_g1     = r_a_sh[0] & r_b_sh[0];
    assign w_s      = w_p ^ r_c;
    assign w_g2     = w_p & r_c;
    assign w_c_next = w_g1 | w_g2;

    assign w_accept = (r_state == S_IDLE) && start;
    assign w_last   = (r_state == S_RUN) && (r_cnt == CNT_W'(WIDTH - 1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start)  w_state_next = S_RUN;
            S_RUN:   if (w_last) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy = (r_state != S_IDLE);
        done = (r_state == S_DONE);
        sum  = r_sum;
        cout = r_cout;
        ovf  = r_ovf;
    end

    // Serial datapath and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_result <= '0;
            r_c      <= 1'b0;
            r_cnt    <= '0;
            r_sum    <= '0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
        end else if (w_accept) begin
            // Subtraction is a + ~b + 1: invert B and force the initial carry.
            r_a_sh   <= a;
            r_b_sh   <= sub ? ~b : b;
            r_c      <= sub ? 1'b1 : cin;
            r_cnt    <= '0;
        end else if (r_state == S_RUN) begin
            r_a_sh   <= {1'b0, r_a_sh[WIDTH-1:1]};
            r_b_sh   <= {1'b0, r_b_sh[WIDTH-1:1]};
            r_result <= {w_s, r_result[WIDTH-1:1]};
            r_c      <= w_c_next;
            if (!w_last) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            // On the MSB edge r_c is the carry into the MSB, so the final
            // result, carry-out and overflow are all known here and land in
            // the output registers exactly as the FSM enters DONE.
            if (w_last) begin
                r_sum  <= {w_s, r_result[WIDTH-1:1]};
                r_cout <= w_c_next;
                r_ovf  <= r_c ^ w_c_next;
            end
        end
    end

endmodule

// File: tb/tb_serial_add_sequencer.sv
module tb_serial_add_sequencer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         sub;
    logic         cin;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int           n_vec = 0;
    int           n_err = 0;
    int           n_done = 0;
    int           cyc = 0;
    logic         prev_done = 1'b0;
    logic [W+1:0] exp_q[$];

    serial_add_sequencer #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .sub   (sub),
        .cin   (cin),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Reference: plain wide addition, overflow from operand/result sign bits.
    function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                           input logic ms, input logic mc);
        logic [W-1:0] bb;
        logic         c0;
        logic [W:0]   full;
        logic         ov;
        bb   = ms ? ~mb : mb;
        c0   = ms ? 1'b1 : mc;
        full = {1'b0, ma} + {1'b0, bb} + {{W{1'b0}}, c0};
        ov   = (ma[W-1] == bb[W-1]) && (full[W-1] != ma[W-1]);
        return {full[W-1:0], full[W], ov};
    endfunction

    // Scoreboard: every done pulse pops one expected result.
    initial forever begin
        @(negedge clk);
        if (done) begin
            logic [W+1:0] e;
            n_done++;
            n_vec++;
            if (prev_done) begin
                n_err++;
                $display("FAIL done_width: done high in two consecutive cycles");
            end
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_done: sum=%h cout=%b ovf=%b with nothing pending", sum, cout, ovf);
            end else begin
                e = exp_q.pop_front();
                if ({sum, cout, ovf} !== e) begin
                    n_err++;
                    $display("FAIL result: got sum=%h cout=%b ovf=%b, want sum=%h cout=%b ovf=%b",
                             sum, cout, ovf, e[W+1:2], e[1], e[0]);
                end
            end
        end
        prev_done = done;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Drives one start pulse; returns at the negedge after the accepting edge.
    task automatic issue(input logic [W-1:0] oa, input logic [W-1:0] ob,
                         input logic os, input logic oc, input bit push);
        @(negedge clk);
        a = oa; b = ob; sub = os; cin = oc; start = 1'b1;
        if (push) exp_q.push_back(model(oa, ob, os, oc));
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts edges from the accepting edge (counted as 1) until done is seen.
    task automatic wait_done(output int edges);
        edges = 1;
        while (!done && edges < 40) begin
            @(negedge clk);
            edges++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_vec++;
        if ({busy, done, sum, cout, ovf} !== '0) begin
            n_err++;
            $display("FAIL reset_state: busy=%b done=%b sum=%h cout=%b ovf=%b, want all 0",
                     busy, done, sum, cout, ovf);
        end
        rst = 1'b0;
    endtask

    task automatic test_add;
        int e;
        issue(8'h5A, 8'h3C, 1'b0, 1'b0, 1'b1);
        n_vec++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL add_busy: busy=%b want 1", busy);
        end
        wait_done(e);
        n_vec++;
        if (e !== W + 1) begin
            n_err++;
            $display("FAIL add_latency: %0d edges, want %0d", e, W + 1);
        end
        n_vec++;
        if ({sum, cout, ovf} !== {8'h96, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL add_const: sum=%h cout=%b ovf=%b, want 96 0 1", sum, cout, ovf);
        end
        repeat (3) @(negedge clk);
        n_vec++;
        if ({busy, done, sum} !== {1'b0, 1'b0, 8'h96}) begin
            n_err++;
            $display("FAIL add_hold: busy=%b done=%b sum=%h, want 0 0 96", busy, done, sum);
        end
    endtask

    task automatic test_carry;
        int e;
        issue(8'hFF, 8'h01, 1'b0, 1'b0, 1'b1);
        wait_done(e);
        n_vec++;
        if (e !== W + 1) begin
            n_err++;
            $display("FAIL carry1_latency: %0d edges, want %0d", e, W + 1);
        end
        issue(8'hFF, 8'h00, 1'b0, 1'b1, 1'b1);
        wait_done(e);
        n_vec++;
        if ({sum, cout, ovf} !== {8'h00, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL carry_cin: sum=%h cout=%b ovf=%b, want 00 1 0", sum, cout, ovf);
        end
    endtask

    task automatic test_sub;
        int e;
        issue(8'h10, 8'h20, 1'b1, 1'b1, 1'b1);
        wait_done(e);
        n_vec++;
        if ({sum, cout, ovf} !== {8'hF0, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL sub_borrow: sum=%h cout=%b ovf=%b, want F0 0 0", sum, cout, ovf);
        end
        issue(8'h80, 8'h01, 1'b1, 1'b0, 1'b1);
        wait_done(e);
        n_vec++;
        if ({sum, cout, ovf} !== {8'h7F, 1'b1, 1'b1}) begin
            n_err++;
            $display("FAIL sub_ovf: sum=%h cout=%b ovf=%b, want 7F 1 1", sum, cout, ovf);
        end
    endtask

    // Random operands; inputs are scrambled after acceptance to show they are ignored.
    task automatic test_random;
        int e;
        for (int i = 0; i < 8; i++) begin
            issue(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 1'b1);
            a = W'($urandom); b = W'($urandom); sub = ~sub; cin = ~cin;
            wait_done(e);
            n_vec++;
            if (e !== W + 1) begin
                n_err++;
                $display("FAIL random_latency[%0d]: %0d edges, want %0d", i, e, W + 1);
            end
        end
    endtask

    task automatic test_busy_lockout;
        int e;
        int n0;
        n0 = n_done;
        issue(8'h01, 8'h01, 1'b0, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        a = 8'hAA; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(e);
        repeat (15) @(negedge clk);
        n_vec++;
        if (n_done - n0 !== 1) begin
            n_err++;
            $display("FAIL lockout_pulses: %0d done pulses, want 1", n_done - n0);
        end
        n_vec++;
        if (sum !== 8'h02) begin
            n_err++;
            $display("FAIL lockout_sum: sum=%h, want 02", sum);
        end
    endtask

    task automatic test_reset_mid;
        int e;
        int n0;
        issue(8'h11, 8'h22, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_vec++;
        if ({busy, done, sum, cout, ovf} !== '0) begin
            n_err++;
            $display("FAIL midrun_reset: busy=%b done=%b sum=%h cout=%b ovf=%b, want all 0",
                     busy, done, sum, cout, ovf);
        end
        n0 = n_done;
        repeat (15) @(negedge clk);
        n_vec++;
        if (n_done !== n0) begin
            n_err++;
            $display("FAIL midrun_no_done: %0d done pulses after abort, want 0", n_done - n0);
        end
        issue(8'h03, 8'h04, 1'b0, 1'b0, 1'b1);
        wait_done(e);
        n_vec++;
        if (e !== W + 1) begin
            n_err++;
            $display("FAIL after_reset_latency: %0d edges, want %0d", e, W + 1);
        end
        // rst and start on the same edge: reset must win.
        @(negedge clk);
        rst = 1'b1; start = 1'b1; a = 8'h55; b = 8'h11;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL rst_vs_start: busy=%b, want 0", busy);
        end
    endtask

    task automatic test_back_to_back;
        int n0;
        int k;
        int t_prev;
        logic [W-1:0] oa;
        logic [W-1:0] ob;
        n0 = n_done;
        t_prev = 0;
        @(negedge clk);
        oa = W'($urandom); ob = W'($urandom);
        a = oa; b = ob; sub = 1'b0; cin = 1'b0; start = 1'b1;
        exp_q.push_back(model(oa, ob, 1'b0, 1'b0));
        for (int i = 0; i < 4; i++) begin
            k = 0;
            do begin
                @(negedge clk);
                k++;
            end while (!done && k < 40);
            n_vec++;
            if (!done) begin
                n_err++;
                $display("FAIL b2b_timeout[%0d]: done=%b after %0d cycles, want 1", i, done, k);
            end
            if (i > 0) begin
                n_vec++;
                if (cyc - t_prev !== W + 2) begin
                    n_err++;
                    $display("FAIL b2b_period[%0d]: %0d cycles, want %0d", i, cyc - t_prev, W + 2);
                end
            end
            t_prev = cyc;
            if (i < 3) begin
                oa = W'($urandom); ob = W'($urandom);
                a = oa; b = ob;
                exp_q.push_back(model(oa, ob, 1'b0, 1'b0));
            end else begin
                start = 1'b0;
            end
        end
        repeat (15) @(negedge clk);
        n_vec++;
        if (n_done - n0 !== 4) begin
            n_err++;
            $display("FAIL b2b_count: %0d done pulses, want 4", n_done - n0);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
        test_reset;
        test_add;
        test_carry;
        test_sub;
        test_random;
        test_busy_lockout;
        test_reset_mid;
        test_back_to_back;
        repeat (3) @(negedge clk);
        n_vec++;
        if (exp_q.size() !== 0) begin
            n_err++;
            $display("FAIL pending: %0d results never produced, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
